// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
//
// Owns the PC and fetches from a request/response instruction memory.
// Only one request is outstanding at a time. A one-entry skid buffer
// holds a word that returns while decode is stalled.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   hazard_detected   decode stall: hold IF/ID and PC
//   IF_Flush          taken branch: redirect to branch_target, squash IF/ID
//   branch_target     redirect address
//   imem_req/addr     request strobe and address (combinational)
//   imem_rvalid/rdata response strobe and instruction word
//   id_instr          IF/ID instruction
//   id_pc_plus4       IF/ID PC+4
//   id_valid          IF/ID holds a real instruction
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_detected,
  input  logic        IF_Flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  // ISSUE: ready to request; WAIT: response pending;
  // DISCARD: response pending but squashed by a flush
  typedef enum logic [1:0] {ISSUE, WAIT, DISCARD} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next, pc_plus4;
  logic        buf_valid, buf_valid_next;
  logic [31:0] buf_instr, buf_instr_next;
  logic [31:0] buf_pc4, buf_pc4_next;
  logic [31:0] id_instr_next, id_pc4_next;
  logic        id_valid_next;
  logic        issue;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    buf_valid_next = buf_valid;
    buf_instr_next = buf_instr;
    buf_pc4_next   = buf_pc4;
    id_instr_next  = id_instr;
    id_pc4_next    = id_pc_plus4;
    id_valid_next  = id_valid;
    issue          = 1'b0;
    // In WAIT a request only goes out back-to-back with a response,
    // and by then the PC it targets is pc+4.
    imem_addr      = (state == WAIT) ? pc_plus4 : pc;

    case (state)
      ISSUE: begin
        if (IF_Flush) begin
          pc_next        = branch_target;
          buf_valid_next = 1'b0;
          id_instr_next  = NOP_INSTR;
          id_pc4_next    = 32'd0;
          id_valid_next  = 1'b0;
        end else begin
          // A buffered word blocks new requests until decode drains it.
          issue = !buf_valid || !hazard_detected;
          if (!hazard_detected) begin
            if (buf_valid) begin
              id_instr_next  = buf_instr;
              id_pc4_next    = buf_pc4;
              id_valid_next  = 1'b1;
              buf_valid_next = 1'b0;
            end else begin
              id_instr_next = NOP_INSTR;
              id_pc4_next   = 32'd0;
              id_valid_next = 1'b0;
            end
          end
          if (issue) state_next = WAIT;
        end
      end

      WAIT: begin
        if (IF_Flush) begin
          pc_next        = branch_target;
          buf_valid_next = 1'b0;
          id_instr_next  = NOP_INSTR;
          id_pc4_next    = 32'd0;
          id_valid_next  = 1'b0;
          state_next     = imem_rvalid ? ISSUE : DISCARD;
        end else if (imem_rvalid) begin
          pc_next = pc_plus4;
          if (!hazard_detected) begin
            id_instr_next = imem_rdata;
            id_pc4_next   = pc_plus4;
            id_valid_next = 1'b1;
            issue         = 1'b1;
          end else begin
            buf_instr_next = imem_rdata;
            buf_pc4_next   = pc_plus4;
            buf_valid_next = 1'b1;
            state_next     = ISSUE;
          end
        end else if (!hazard_detected) begin
          id_instr_next = NOP_INSTR;
          id_pc4_next   = 32'd0;
          id_valid_next = 1'b0;
        end
      end

      DISCARD: begin
        if (IF_Flush) pc_next = branch_target;
        if (IF_Flush || !hazard_detected) begin
          id_instr_next = NOP_INSTR;
          id_pc4_next   = 32'd0;
          id_valid_next = 1'b0;
        end
        if (imem_rvalid) state_next = ISSUE;
      end

      default: state_next = ISSUE;
    endcase

    imem_req = issue && rst;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ISSUE;
      pc          <= RESET_PC;
      buf_valid   <= 1'b0;
      buf_instr   <= NOP_INSTR;
      buf_pc4     <= 32'd0;
      id_instr    <= NOP_INSTR;
      id_pc_plus4 <= 32'd0;
      id_valid    <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      buf_valid   <= buf_valid_next;
      buf_instr   <= buf_instr_next;
      buf_pc4     <= buf_pc4_next;
      id_instr    <= id_instr_next;
      id_pc_plus4 <= id_pc4_next;
      id_valid    <= id_valid_next;
    end
  end

endmodule
